// File: rtl/alu_feeder.sv
// Instruction-issue stage in front of the 8-bit accumulator ALU: buffers producer
// instructions in a small FIFO, drops undefined opcodes, and issues one per cycle.
module alu_feeder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [11:0]       in_inst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    input  logic              flush,
    output logic [11:0]       out_inst,
    output logic              out_wen,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        drop_count,
    output logic              error
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAST_OPCODE = 4'd9;

    state_t            state;
    logic [ADDR_W:0]   head;
    logic [ADDR_W:0]   tail;
    logic [11:0]       mem [DEPTH];

    logic              full;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count    = tail - head;
    assign full     = (count == FULL_COUNT);
    assign in_ready = (state == RUN) && !full && !flush;
    assign legal    = (in_inst[11:8] <= LAST_OPCODE);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = (state == RUN) && !hold && !flush && (count != '0);

    // NOTE: storage has no reset; only pointers mark which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail[ADDR_W-1:0]] <= in_inst;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, letting push and pop share one edge safely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            head       <= '0;
            tail       <= '0;
            out_inst   <= 12'h000;
            out_wen    <= 1'b0;
            error      <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            out_wen <= 1'b0;
            if (state == INIT) begin
                state <= RUN;
            end else if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (accept && !legal) begin
                    error <= 1'b1;
                    if (drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                    end
                end
                if (pop) begin
                    out_inst <= mem[head[ADDR_W-1:0]];
                    out_wen  <= 1'b1;
                    head     <= head + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_feeder.sv
// Self-checking bench for alu_feeder against a queue-based instruction model.
module tb_alu_feeder;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] in_inst = '0;
    logic        in_valid = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic [11:0] out_inst;
    logic        out_wen;
    logic [2:0]  count;
    logic [7:0]  drop_count;
    logic        error;

    always #5 clock = ~clock;

    alu_feeder #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clock(clock),
        .reset(reset),
        .in_inst(in_inst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .hold(hold),
        .flush(flush),
        .out_inst(out_inst),
        .out_wen(out_wen),
        .count(count),
        .drop_count(drop_count),
        .error(error)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is a plain queue of instructions.
    logic [11:0] q[$];
    bit          m_run;
    logic        m_wen;
    logic [11:0] m_out;
    logic        m_err;
    int          m_drops;
    logic        m_ready;
    logic        seen_ready;
    logic [11:0] obs[$];
    logic [11:0] sent[$];

    task automatic model_reset();
        q.delete();
        m_run   = 0;
        m_wen   = 1'b0;
        m_out   = 12'h000;
        m_err   = 1'b0;
        m_drops = 0;
    endtask

    // One clock: drive inputs, sample in_ready mid-cycle, advance model at the edge.
    task automatic cycle(input logic v, input logic [11:0] i, input logic h, input logic f);
        bit do_pop;
        in_valid = v;
        in_inst  = i;
        hold     = h;
        flush    = f;
        #3;
        seen_ready = in_ready;
        m_ready    = m_run && (q.size() < DEPTH) && !f;
        @(posedge clock);
        if (!m_run) begin
            m_run = 1;
            m_wen = 1'b0;
        end else if (f) begin
            q.delete();
            m_wen = 1'b0;
        end else begin
            do_pop = !h && (q.size() > 0);
            m_wen  = do_pop;
            if (do_pop) m_out = q.pop_front();
            if (v && m_ready) begin
                if (i[11:8] <= 4'd9) q.push_back(i);
                else begin
                    m_err = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_wen !== 1'b0) begin errors++; $display("FAIL reset out_wen: got %b expected 0", out_wen); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        checks++; if (out_inst !== 12'h000) begin errors++; $display("FAIL reset out_inst: got %h expected 000", out_inst); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset error: got %b expected 0", error); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset drop_count: got %0d expected 0", drop_count); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(c < 2, 12'h105, 1'b0, 1'b0);
            if (c == 0) begin
                checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL init in_ready: got %b expected 0", seen_ready); end
            end
            checks++; if (seen_ready !== m_ready) begin errors++; $display("FAIL first_push in_ready c%0d: got %b expected %b", c, seen_ready, m_ready); end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL first_push out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            if (m_wen) begin
                checks++; if (out_inst !== m_out) begin errors++; $display("FAIL first_push out_inst c%0d: got %h expected %h", c, out_inst, m_out); end
            end
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL first_push count c%0d: got %0d expected %0d", c, count, q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] stim [4] = '{12'h105, 12'h203, 12'h301, 12'h4FF};
        logic [11:0] exp_order [5] = '{12'h105, 12'h203, 12'h301, 12'h4FF, 12'h601};
        bit pending = 0;
        obs.delete();
        for (int c = 0; c < 17; c++) begin
            if (c < 4) cycle(1'b1, stim[c], 1'b1, 1'b0);
            else if (c == 4) begin
                pending = 1;
                cycle(1'b1, 12'h601, 1'b1, 1'b0);
                checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL full in_ready: got %b expected 0", seen_ready); end
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL full count: got %0d expected 4", count); end
            end else cycle(pending, 12'h601, 1'b0, 1'b0);
            if (pending && in_valid && seen_ready) pending = 0;
            if (out_wen) obs.push_back(out_inst);
            checks++; if (seen_ready !== m_ready) begin errors++; $display("FAIL b2b in_ready c%0d: got %b expected %b", c, seen_ready, m_ready); end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL b2b out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            if (m_wen) begin
                checks++; if (out_inst !== m_out) begin errors++; $display("FAIL b2b out_inst c%0d: got %h expected %h", c, out_inst, m_out); end
            end
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL b2b count c%0d: got %0d expected %0d", c, count, q.size()); end
        end
        checks++; if (obs.size() != 5) begin errors++; $display("FAIL b2b issue_count: got %0d expected 5", obs.size()); end
        for (int k = 0; k < 5 && k < obs.size(); k++) begin
            checks++; if (obs[k] !== exp_order[k]) begin errors++; $display("FAIL b2b order[%0d]: got %h expected %h", k, obs[k], exp_order[k]); end
        end
    endtask

    task automatic test_stream();
        logic [11:0] inst;
        obs.delete();
        sent.delete();
        for (int c = 0; c < 13; c++) begin
            inst = {4'($urandom_range(0, 9)), 8'($urandom)};
            if (c < 10) sent.push_back(inst);
            cycle(c < 10, inst, 1'b0, 1'b0);
            if (out_wen) obs.push_back(out_inst);
            checks++; if (seen_ready !== m_ready) begin errors++; $display("FAIL stream in_ready c%0d: got %b expected %b", c, seen_ready, m_ready); end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL stream out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            if (m_wen) begin
                checks++; if (out_inst !== m_out) begin errors++; $display("FAIL stream out_inst c%0d: got %h expected %h", c, out_inst, m_out); end
            end
            checks++; if (count > 3'd1) begin errors++; $display("FAIL stream count c%0d: got %0d expected <=1", c, count); end
        end
        checks++; if (obs != sent) begin errors++; $display("FAIL stream sequence: got %0d issues expected %0d in order", obs.size(), sent.size()); end
    endtask

    task automatic test_illegal();
        obs.delete();
        for (int c = 0; c < 304; c++) begin
            if (c == 0) cycle(1'b1, 12'hA12, 1'b0, 1'b0);
            else if (c == 1) cycle(1'b1, 12'h207, 1'b0, 1'b0);
            else if (c < 4) cycle(1'b0, 12'h000, 1'b0, 1'b0);
            else cycle(1'b1, {4'($urandom_range(10, 15)), 8'($urandom)}, 1'b0, 1'b0);
            if (c < 4 && out_wen) obs.push_back(out_inst);
            if (c == 3) begin
                checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal error: got %b expected 1", error); end
                checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL illegal drop_count: got %0d expected 1", drop_count); end
                checks++; if (obs.size() != 1 || obs[0] !== 12'h207) begin errors++; $display("FAIL illegal issued: got %0d issues expected only 207", obs.size()); end
            end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL illegal out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            checks++; if (error !== m_err) begin errors++; $display("FAIL illegal error c%0d: got %b expected %b", c, error, m_err); end
            checks++; if (drop_count !== 8'(m_drops)) begin errors++; $display("FAIL illegal drops c%0d: got %0d expected %0d", c, drop_count, m_drops); end
        end
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", drop_count); end
    endtask

    task automatic test_flush();
        logic [7:0] drops_before;
        logic       err_before;
        drops_before = drop_count;
        err_before   = error;
        for (int c = 0; c < 7; c++) begin
            if (c < 3) cycle(1'b1, 12'h110 + 12'(c), 1'b1, 1'b0);
            else if (c == 3) cycle(1'b1, 12'h155, 1'b1, 1'b1);
            else cycle(c == 4, 12'h3AB, 1'b0, 1'b0);
            if (c == 3) begin
                checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL flush in_ready: got %b expected 0", seen_ready); end
                checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush count: got %0d expected 0", count); end
                checks++; if (error !== err_before || drop_count !== drops_before) begin errors++; $display("FAIL flush status: got %b/%0d expected %b/%0d", error, drop_count, err_before, drops_before); end
            end
            checks++; if (seen_ready !== m_ready) begin errors++; $display("FAIL flush in_ready c%0d: got %b expected %b", c, seen_ready, m_ready); end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL flush out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            if (m_wen) begin
                checks++; if (out_inst !== m_out) begin errors++; $display("FAIL flush out_inst c%0d: got %h expected %h", c, out_inst, m_out); end
            end
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL flush count c%0d: got %0d expected %0d", c, count, q.size()); end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) cycle(1'b1, 12'h520 + 12'(c), c < 3, 1'b0);
        checks++; if (out_wen !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL reset_mid setup: got wen %b count %0d expected 1/3", out_wen, count); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (out_wen !== 1'b0) begin errors++; $display("FAIL reset_mid out_wen: got %b expected 0", out_wen); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_mid count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid in_ready: got %b expected 0", in_ready); end
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(c < 2, 12'h1C3, 1'b0, 1'b0);
            checks++; if (seen_ready !== m_ready) begin errors++; $display("FAIL reset_mid in_ready c%0d: got %b expected %b", c, seen_ready, m_ready); end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL reset_mid out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            if (m_wen) begin
                checks++; if (out_inst !== m_out) begin errors++; $display("FAIL reset_mid out_inst c%0d: got %h expected %h", c, out_inst, m_out); end
            end
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL reset_mid count c%0d: got %0d expected %0d", c, count, q.size()); end
        end
    endtask

    task automatic test_random();
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
        for (int c = 0; c < 300; c++) begin
            cycle($urandom_range(0, 9) < 7, 12'($urandom), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0);
            checks++; if (seen_ready !== m_ready) begin errors++; $display("FAIL random in_ready c%0d: got %b expected %b", c, seen_ready, m_ready); end
            checks++; if (out_wen !== m_wen) begin errors++; $display("FAIL random out_wen c%0d: got %b expected %b", c, out_wen, m_wen); end
            if (m_wen) begin
                checks++; if (out_inst !== m_out) begin errors++; $display("FAIL random out_inst c%0d: got %h expected %h", c, out_inst, m_out); end
            end
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL random count c%0d: got %0d expected %0d", c, count, q.size()); end
            checks++; if (error !== m_err || drop_count !== 8'(m_drops)) begin errors++; $display("FAIL random status c%0d: got %b/%0d expected %b/%0d", c, error, drop_count, m_err, m_drops); end
        end
    endtask

    initial begin
        model_reset();
        #1;
        reset = 1'b0;
        test_reset();
        test_back_to_back();
        test_stream();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_feeder.md
Name: alu_feeder

Overview:
- Instruction-issue stage directly upstream of the 8-bit accumulator ALU.
- Accepts 12-bit ALU instructions from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one instruction per cycle on the ALU's inst/inst_wen interface.
- Screens out undefined opcodes so the ALU is never driven into its Error state.

Parameters:
- DEPTH, 4, FIFO capacity in instructions; must be a power of 2, at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_inst  input  12  producer instruction: [11:8] opcode, [7:0] immediate.
- in_valid  input  1  producer has an instruction on in_inst.
- in_ready  output  1  feeder can accept this cycle.
- hold  input  1  downstream pause; no issue while high.
- flush  input  1  synchronous FIFO clear.
- out_inst  output  12  instruction to the ALU inst port.
- out_wen  output  1  one-cycle strobe to the ALU inst_wen port.
- count  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- drop_count  output  8  number of rejected illegal instructions; saturates at 255.
- error  output  1  sticky: at least one illegal opcode has been seen since reset.

Behaviour:
- Reset (reset==0), asynchronous:
  - Pointers cleared; count=0; out_inst=12'h000; out_wen=0; in_ready=0; error=0; drop_count=0; state=INIT.
- States: INIT and RUN.
  - INIT lasts exactly one clock edge after reset deasserts. This matches the ALU's own Reset->Ready cycle.
  - While in INIT: in_ready=0 and out_wen=0.
  - INIT always goes to RUN. RUN holds until reset.
- in_ready (RUN only): in_ready = !full && !flush. It is combinational from registered state and flush only, never from in_valid.
- Accept: occurs on an edge where in_valid && in_ready.
  - Legal opcode (0x0..0x9): written at the tail; tail pointer increments modulo DEPTH.
  - Illegal opcode (0xA..0xF): not written; error<=1; drop_count increments, saturating at 255.
- Issue (RUN, !hold, !flush, count>0 before the edge):
  - Head entry is registered into out_inst; out_wen<=1 for that cycle only; head pointer increments modulo DEPTH.
- No issue: out_wen<=0; out_inst keeps its last value.
- Latency:
  - An instruction accepted at edge N into an empty FIFO is issued at edge N+1.
  - out_wen is high during the cycle after edge N+1.
  - There is no bypass path.
- Push and pop on the same edge: both take effect and count is unchanged.
- Full FIFO: in_ready=0 even if a pop occurs on the same edge. There is no same-cycle refill.
- Empty FIFO with hold low: out_wen=0. No underflow; pointers do not move.
- hold: sampled at each edge. When high, no pop, out_wen<=0, and accepts continue while not full.
- flush (RUN):
  - On the edge, pointers and count are cleared and out_wen<=0.
  - No accept happens (in_ready is low).
  - error and drop_count are unaffected.
  - flush has priority over issue and accept.
- count: equals tail minus head occupancy (full distinguished via the extra bit); updated on the same edge as push/pop.
- Reset asserted mid-stream: all buffered instructions are lost immediately and asynchronously. out_wen drops without waiting for the clock.
- FIFO storage is not reset. Only pointers, outputs and status are reset.

Test Plan:
- Reset release, push LDI 0x1_05 in the first cycle after release -> in_ready=0 during INIT, so no accept. Push again in RUN -> out_inst=12'h105 with a single out_wen pulse one edge after the accept.
- Back-to-back push of 0x105, 0x203, 0x301, 0x4FF with hold=1 -> count reaches 4 and in_ready=0. A fifth push of 0x601 is stalled. Release hold -> four consecutive out_wen pulses in order. Fifth instruction is accepted only after the first pop and issued fifth.
- Continuous stream of 10 instructions with hold=0 -> count steady at ≤1 and one issue per cycle in order. Pointers wrap twice with no loss or duplication.
- Push 0xA12, then 0x207 -> 0xA12 is never issued; error=1; drop_count=1; 0x207 is issued. Push 300 illegal instructions -> drop_count=255 (saturates).
- FIFO holding 3 entries with hold=1; assert flush for one cycle with in_valid=1 -> count=0, in_ready=0 that cycle, no out_wen. error and drop_count unchanged. Next push is issued normally.
- Assert reset low mid-stream between edges, with count=3 and out_wen=1 -> out_wen=0, count=0 and in_ready=0 immediately. After release, one INIT cycle, then normal operation.
